// File: rtl/pipelined_armv8_core.sv
// Five-stage in-order LEGv8 core with internal instruction/data memories and register file.
// Branches resolve in ID; EX forwarding, load-use and branch-operand stalls.

module armv8_imem #(
    parameter int WORDS = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);
    logic [31:0] memory [0:WORDS-1];

    always_ff @(posedge clock) if (wr_en) memory[wr_addr] <= wr_data;
    assign rd_data = memory[rd_addr];
endmodule

module armv8_fetch #(
    parameter int IMEM_WORDS = 64,
    parameter int AW         = $clog2(IMEM_WORDS)
) (
    input  logic          clock,
    input  logic [AW-1:0] pc_idx,
    output logic [31:0]   instr
);
    // Contents come from preload only; the write port stays idle.
    armv8_imem #(.WORDS(IMEM_WORDS)) instruction_memory (
        .clock(clock), .wr_en(1'b0), .wr_addr('0), .wr_data(32'd0),
        .rd_addr(pc_idx), .rd_data(instr)
    );
endmodule

module armv8_regfile (
    input  logic        clock,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [63:0] wd,
    output logic [63:0] rd1,
    output logic [63:0] rd2
);
    logic [63:0] regfile [0:31];

    always_ff @(posedge clock) if (we && wa != 5'd31) regfile[wa] <= wd;

    // Write-through so a WB producer is visible to the same-cycle ID read.
    always_comb begin
        rd1 = regfile[ra1];
        rd2 = regfile[ra2];
        if (we && wa == ra1) rd1 = wd;
        if (we && wa == ra2) rd2 = wd;
        if (ra1 == 5'd31) rd1 = '0;
        if (ra2 == 5'd31) rd2 = '0;
    end
endmodule

module armv8_decode (
    input  logic        clock,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [63:0] wd,
    output logic [63:0] rd1,
    output logic [63:0] rd2
);
    armv8_regfile registers (
        .clock(clock), .ra1(ra1), .ra2(ra2), .we(we), .wa(wa), .wd(wd),
        .rd1(rd1), .rd2(rd2)
    );
endmodule

module pipelined_armv8_core #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic clock,
    input  logic reset,
    output logic uitgang
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_op_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        alu_op_e     alu_op;
        logic        use_imm;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [63:0] store;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rd;
        logic [63:0] data;
    } mem_wb_t;

    logic [63:0] pc_q, pc_d, if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d, fetch_instr, instr;
    id_ex_t      id_ex_q, id_ex_d, dec;
    ex_mem_t     ex_mem_q, ex_mem_d;
    mem_wb_t     mem_wb_q, mem_wb_d;
    logic [63:0] dmem [0:DMEM_WORDS-1];

    armv8_fetch #(.IMEM_WORDS(IMEM_WORDS)) instruction_fetch (
        .clock(clock), .pc_idx(pc_q[IAW+1:2]), .instr(fetch_instr)
    );

    // ---------------- ID ----------------
    logic        is_r, is_i, is_ld, is_st, is_cbz, is_cbnz, is_b;
    logic [4:0]  rn, rs2, rt;
    logic [63:0] rd1, rd2, cb_val, target;
    logic        load_use, cb_stall, stall, taken;

    assign instr = if_id_instr_q;
    assign rn    = instr[9:5];
    assign rt    = instr[4:0];
    assign rs2   = is_r ? instr[20:16] : instr[4:0];

    armv8_decode instruction_decode (
        .clock(clock), .ra1(rn), .ra2(rs2),
        .we(mem_wb_q.reg_write), .wa(mem_wb_q.rd), .wd(mem_wb_q.data),
        .rd1(rd1), .rd2(rd2)
    );

    always_comb begin
        is_r    = instr[31:21] inside {11'b10001011000, 11'b11001011000,
                                       11'b10001010000, 11'b10101010000};
        is_i    = instr[31:22] inside {10'b1001000100, 10'b1101000100};
        is_ld   = instr[31:21] == 11'b11111000010;
        is_st   = instr[31:21] == 11'b11111000000;
        is_cbz  = instr[31:24] == 8'b10110100;
        is_cbnz = instr[31:24] == 8'b10110101;
        is_b    = instr[31:26] == 6'b000101;
    end

    always_comb begin
        dec           = '0;
        dec.rd        = rt;
        dec.rn        = rn;
        dec.rm        = rs2;
        dec.a         = rd1;
        dec.b         = rd2;
        dec.reg_write = (is_r || is_i || is_ld) && rt != 5'd31;
        dec.mem_read  = is_ld;
        dec.mem_write = is_st;
        dec.use_imm   = is_i || is_ld || is_st;
        dec.imm       = is_i ? {52'd0, instr[21:10]} : {{55{instr[20]}}, instr[20:12]};
        case (instr[31:21])
            11'b11001011000: dec.alu_op = ALU_SUB;
            11'b10001010000: dec.alu_op = ALU_AND;
            11'b10101010000: dec.alu_op = ALU_ORR;
            default:         dec.alu_op = (instr[31:22] == 10'b1101000100) ? ALU_SUB : ALU_ADD;
        endcase
    end

    // reg_write is never set for X31, so XZR sources can never match here.
    always_comb begin
        load_use = id_ex_q.mem_read && id_ex_q.reg_write &&
                   (((is_r || is_i || is_ld || is_st) && id_ex_q.rd == rn) ||
                    ((is_r || is_st) && id_ex_q.rd == rs2));
        cb_stall = (is_cbz || is_cbnz) &&
                   ((id_ex_q.reg_write && id_ex_q.rd == rt) ||
                    (ex_mem_q.mem_read && ex_mem_q.reg_write && ex_mem_q.rd == rt));
        stall    = load_use || cb_stall;
        cb_val   = (ex_mem_q.reg_write && !ex_mem_q.mem_read && ex_mem_q.rd == rt) ?
                   ex_mem_q.alu : rd2;
        taken    = !stall && (is_b || (is_cbz && cb_val == 64'd0) ||
                              (is_cbnz && cb_val != 64'd0));
        target   = if_id_pc_q + (is_b ? {{36{instr[25]}}, instr[25:0], 2'b00}
                                      : {{43{instr[23]}}, instr[23:5], 2'b00});
    end

    always_comb begin
        pc_d          = pc_q + 64'd4;
        if_id_instr_d = fetch_instr;
        if_id_pc_d    = pc_q;
        id_ex_d       = dec;
        if (stall) begin
            pc_d          = pc_q;
            if_id_instr_d = if_id_instr_q;
            if_id_pc_d    = if_id_pc_q;
            id_ex_d       = '0;
        end else if (taken) begin
            pc_d          = target;
            if_id_instr_d = 32'd0;
        end
    end

    // ---------------- EX ----------------
    logic [63:0] fwd_a, fwd_b, op_b, alu;

    always_comb begin
        fwd_a = id_ex_q.a;
        fwd_b = id_ex_q.b;
        if (mem_wb_q.reg_write && mem_wb_q.rd == id_ex_q.rn) fwd_a = mem_wb_q.data;
        if (mem_wb_q.reg_write && mem_wb_q.rd == id_ex_q.rm) fwd_b = mem_wb_q.data;
        if (ex_mem_q.reg_write && ex_mem_q.rd == id_ex_q.rn) fwd_a = ex_mem_q.alu;
        if (ex_mem_q.reg_write && ex_mem_q.rd == id_ex_q.rm) fwd_b = ex_mem_q.alu;
        op_b = id_ex_q.use_imm ? id_ex_q.imm : fwd_b;
        case (id_ex_q.alu_op)
            ALU_SUB: alu = fwd_a - op_b;
            ALU_AND: alu = fwd_a & op_b;
            ALU_ORR: alu = fwd_a | op_b;
            default: alu = fwd_a + op_b;
        endcase
        ex_mem_d.reg_write = id_ex_q.reg_write;
        ex_mem_d.mem_read  = id_ex_q.mem_read;
        ex_mem_d.mem_write = id_ex_q.mem_write;
        ex_mem_d.rd        = id_ex_q.rd;
        ex_mem_d.alu       = alu;
        ex_mem_d.store     = fwd_b;
    end

    // ---------------- MEM / WB ----------------
    always_ff @(posedge clock)
        if (ex_mem_q.mem_write) dmem[ex_mem_q.alu[DAW+2:3]] <= ex_mem_q.store;

    always_comb begin
        mem_wb_d.reg_write = ex_mem_q.reg_write;
        mem_wb_d.rd        = ex_mem_q.rd;
        mem_wb_d.data      = ex_mem_q.mem_read ? dmem[ex_mem_q.alu[DAW+2:3]] : ex_mem_q.alu;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q          <= '0;
            if_id_instr_q <= '0;
            if_id_pc_q    <= '0;
            id_ex_q       <= '0;
            ex_mem_q      <= '0;
            mem_wb_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            id_ex_q       <= id_ex_d;
            ex_mem_q      <= ex_mem_d;
            mem_wb_q      <= mem_wb_d;
        end
    end

    assign uitgang = mem_wb_q.reg_write;
endmodule

// File: tb/tb_pipelined_armv8_core.sv
// Directed spec scenarios with edge-exact timing plus random programs checked
// against an instruction-level interpreter of the LEGv8 subset.

module tb_pipelined_armv8_core;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic uitgang;

    pipelined_armv8_core #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
        .clock(clock), .reset(reset), .uitgang(uitgang)
    );

    always #10 clock = ~clock;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [31:0] HALT    = 32'h14000000;

    logic [31:0] prog  [0:63];
    logic [63:0] m_reg [0:31];
    logic [63:0] m_mem [0:63];
    int m_writes, wb_count, n_checks, n_fail;

    always @(negedge clock) if (uitgang === 1'b1) wb_count++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [10:0] op, input int rd, input int rn, input int rm);
        return {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] enc_i(input logic [9:0] op, input int rd, input int rn, input int imm);
        return {op, 12'(imm), 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] enc_d(input logic [10:0] op, input int rt, input int rn, input int imm);
        return {op, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
    endfunction
    function automatic logic [31:0] enc_cb(input logic [7:0] op, input int rt, input int off);
        return {op, 19'(off), 5'(rt)};
    endfunction

    function automatic logic [63:0] rv(input logic [4:0] r);
        return (r == 5'd31) ? 64'd0 : m_reg[r];
    endfunction
    task automatic wr(input logic [4:0] r, input logic [63:0] v);
        if (r != 5'd31) begin
            m_reg[r] = v;
            m_writes++;
        end
    endtask

    // Architectural interpreter: executes the program once up to the HALT self-loop.
    task automatic model_run();
        int pc;
        pc = 0;
        m_writes = 0;
        for (int s = 0; s < 1000; s++) begin
            logic [31:0] w;
            logic [63:0] a, addr;
            int nxt;
            w = prog[pc];
            if (w == HALT) break;
            a    = rv(w[9:5]);
            addr = a + {{55{w[20]}}, w[20:12]};
            nxt  = (pc + 1) & 63;
            if      (w[31:21] == OP_ADD)  wr(w[4:0], a + rv(w[20:16]));
            else if (w[31:21] == OP_SUB)  wr(w[4:0], a - rv(w[20:16]));
            else if (w[31:21] == OP_AND)  wr(w[4:0], a & rv(w[20:16]));
            else if (w[31:21] == OP_ORR)  wr(w[4:0], a | rv(w[20:16]));
            else if (w[31:22] == OP_ADDI) wr(w[4:0], a + {52'd0, w[21:10]});
            else if (w[31:22] == OP_SUBI) wr(w[4:0], a - {52'd0, w[21:10]});
            else if (w[31:21] == OP_LDUR) wr(w[4:0], m_mem[addr[8:3]]);
            else if (w[31:21] == OP_STUR) m_mem[addr[8:3]] = rv(w[4:0]);
            else if ((w[31:24] == OP_CBZ && rv(w[4:0]) == 0) ||
                     (w[31:24] == OP_CBNZ && rv(w[4:0]) != 0))
                nxt = (pc + int'({{13{w[23]}}, w[23:5]})) & 63;
            else if (w[31:26] == 6'b000101)
                nxt = (pc + int'({{6{w[25]}}, w[25:0]})) & 63;
            pc = nxt;
        end
    endtask

    task automatic load_dut();
        for (int i = 0; i < 64; i++) begin
            dut.instruction_fetch.instruction_memory.memory[i] = prog[i];
            dut.dmem[i] = m_mem[i];
        end
        for (int r = 0; r < 31; r++) dut.instruction_decode.registers.regfile[r] = m_reg[r];
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #5;
    endtask

    function automatic logic [63:0] xr(input int r);
        return dut.instruction_decode.registers.regfile[r];
    endfunction

    function automatic int rreg();
        int r;
        r = int'($urandom_range(0, 7));
        return (r == 7) ? 31 : r;
    endfunction

    task automatic gen_random();
        int len, k, room, off;
        len = 28 + int'($urandom_range(0, 12));
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        for (int i = 0; i < len - 1; i++) begin
            k    = int'($urandom_range(0, 11));
            room = len - 1 - i;
            off  = 1 + int'($urandom_range(0, (room > 3) ? 3 : room - 1));
            case (k)
                0:  prog[i] = enc_r(OP_ADD, rreg(), rreg(), rreg());
                1:  prog[i] = enc_r(OP_SUB, rreg(), rreg(), rreg());
                2:  prog[i] = enc_r(OP_AND, rreg(), rreg(), rreg());
                3:  prog[i] = enc_r(OP_ORR, rreg(), rreg(), rreg());
                4:  prog[i] = enc_i(OP_ADDI, rreg(), rreg(), int'($urandom_range(0, 4095)));
                5:  prog[i] = enc_i(OP_SUBI, rreg(), rreg(), int'($urandom_range(0, 4095)));
                6:  prog[i] = enc_d(OP_LDUR, rreg(), 31, 8 * int'($urandom_range(0, 7)));
                7:  prog[i] = enc_d(OP_STUR, rreg(), 31, 8 * int'($urandom_range(0, 7)));
                8:  prog[i] = enc_cb(OP_CBZ, rreg(), off);
                9:  prog[i] = enc_cb(OP_CBNZ, rreg(), off);
                10: prog[i] = {6'b000101, 26'(off)};
                default: prog[i] = 32'd0;
            endcase
        end
        prog[len-1] = HALT;
        for (int r = 0; r < 32; r++)
            m_reg[r] = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 2)) : {$urandom, $urandom};
        for (int m = 0; m < 64; m++) m_mem[m] = {$urandom, $urandom};
    endtask

    task automatic directed_setup();
        for (int i = 0; i < 64; i++) begin
            prog[i]  = 32'd0;
            m_mem[i] = 64'd0;
        end
        for (int r = 0; r < 32; r++) m_reg[r] = 64'd0;
        m_reg[2] = 64'd80; m_reg[16] = 64'd2; m_reg[18] = 64'd1;
        prog[0]  = enc_r(OP_SUB, 16, 16, 18);
        prog[1]  = enc_cb(OP_CBZ, 16, 6);
        prog[2]  = enc_r(OP_SUB, 16, 16, 18);
        prog[3]  = enc_cb(OP_CBZ, 16, 4);
        prog[4]  = enc_r(OP_ADD, 16, 16, 18);
        prog[5]  = enc_r(OP_ADD, 16, 16, 18);
        prog[6]  = enc_r(OP_ADD, 16, 16, 18);
        prog[7]  = enc_r(OP_ADD, 16, 16, 2);
        prog[8]  = enc_i(OP_SUBI, 16, 16, 80);
        prog[9]  = enc_cb(OP_CBNZ, 16, 6);
        prog[10] = enc_r(OP_ADD, 16, 16, 18);
        prog[11] = enc_cb(OP_CBNZ, 16, 4);
        prog[12] = enc_r(OP_ADD, 16, 16, 18);
        prog[13] = enc_r(OP_ADD, 16, 16, 18);
        prog[14] = enc_r(OP_ADD, 16, 16, 18);
        prog[15] = enc_r(OP_ADD, 16, 16, 2);
        prog[16] = enc_r(OP_ADD, 1, 2, 18);
        prog[17] = enc_r(OP_ADD, 3, 1, 1);
        prog[18] = enc_d(OP_STUR, 2, 31, 8);
        prog[19] = enc_d(OP_LDUR, 4, 31, 8);
        prog[20] = enc_r(OP_ADD, 5, 4, 18);
        prog[21] = enc_d(OP_STUR, 18, 2, -16);
        prog[22] = enc_d(OP_LDUR, 6, 31, 64);
        prog[23] = HALT;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; wb_count = 0;

        // Directed run with edge-exact timing; reset released at 15 ns.
        directed_setup();
        load_dut();
        model_run();
        #15 reset = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step(1);
            check($sformatf("uitgang_edge%0d", e), 64'(uitgang), 64'd0);
        end
        step(1);
        check("uitgang_edge4", 64'(uitgang), 64'd1);
        check("x16_before_wb", xr(16), 64'd2);
        step(1);
        check("x16_first_wb_edge5", xr(16), 64'd1);
        step(3);
        check("x16_zero_edge8", xr(16), 64'd0);
        step(3);
        check("x16_pre_target_edge11", xr(16), 64'd0);
        step(1);
        check("x16_target_edge12", xr(16), 64'd80);
        step(9);
        check("x3_before_edge22", xr(3), 64'd0);
        step(1);
        check("x3_fwd_edge22", xr(3), 64'd162);
        step(3);
        check("x5_before_edge26", xr(5), 64'd0);
        step(1);
        check("x5_loaduse_edge26", xr(5), 64'd81);
        step(20);
        check("x16_final", xr(16), 64'd81);
        check("x6_neg_offset_load", xr(6), 64'd1);
        check("dmem8_neg_offset", dut.dmem[8], 64'd1);
        for (int r = 0; r < 31; r++) check($sformatf("dir_x%0d", r), xr(r), m_reg[r]);
        check("dir_wb_count", 64'(wb_count), 64'(m_writes));

        // Reset mid-program: SUBI in WB must be discarded, earlier writes kept.
        reset = 1'b0;
        directed_setup();
        #1 load_dut();
        wb_count = 0;
        @(negedge clock) reset = 1'b1;
        step(12);
        check("uitgang_before_reset", 64'(uitgang), 64'd1);
        reset = 1'b0;
        #1;
        check("pc_async_reset", dut.pc_q, 64'd0);
        check("uitgang_async_reset", 64'(uitgang), 64'd0);
        step(3);
        check("x16_kept_after_reset", xr(16), 64'd80);
        check("uitgang_held_reset", 64'(uitgang), 64'd0);

        // Random programs against the interpreter.
        for (int t = 0; t < 8; t++) begin
            reset = 1'b0;
            gen_random();
            #1 load_dut();
            model_run();
            wb_count = 0;
            @(negedge clock) reset = 1'b1;
            step(300);
            for (int r = 0; r < 31; r++) check($sformatf("rnd%0d_x%0d", t, r), xr(r), m_reg[r]);
            for (int m = 0; m < 8; m++) check($sformatf("rnd%0d_mem%0d", t, m), dut.dmem[m], m_mem[m]);
            check($sformatf("rnd%0d_wb_count", t), 64'(wb_count), 64'(m_writes));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
